id_ex_stage: RTL and testbench

//  ID/EX pipeline register directly downstream of the general control decoder.

---
 rtl/id_ex_stage.sv | 106 ++++++++++
 tb/tb_id_ex_stage.sv | 131 +++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion, stall hold, flush squash and a saturating bubble counter
module id_ex_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int RA_WIDTH   = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] rs_data_i,
    input  logic [DATA_WIDTH-1:0] rt_data_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    input  logic [RA_WIDTH-1:0]   rs_addr_i,
    input  logic [RA_WIDTH-1:0]   rt_addr_i,
    input  logic [RA_WIDTH-1:0]   rd_addr_i,
    input  logic [3:0]            EX_ctrl_i,
    input  logic [1:0]            MEM_ctrl_i,
    input  logic                  WB_ctrl_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] rs_data_o,
    output logic [DATA_WIDTH-1:0] rt_data_o,
    output logic [DATA_WIDTH-1:0] imm_o,
    output logic [RA_WIDTH-1:0]   rs_addr_o,
    output logic [RA_WIDTH-1:0]   rt_addr_o,
    output logic [RA_WIDTH-1:0]   rd_addr_o,
    output logic [3:0]            EX_ctrl_o,
    output logic [1:0]            MEM_ctrl_o,
    output logic                  WB_ctrl_o,
    output logic [RA_WIDTH-1:0]   dst_addr_o,
    output logic                  hazard_stall_o,
    output logic [CNT_WIDTH-1:0]  bubble_cnt_o
);
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d, rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
    logic [RA_WIDTH-1:0]   rs_addr_q, rs_addr_d, rt_addr_q, rt_addr_d, rd_addr_q, rd_addr_d;
    logic [3:0]            ex_ctrl_q, ex_ctrl_d;
    logic [1:0]            mem_ctrl_q, mem_ctrl_d;
    logic                  wb_ctrl_q, wb_ctrl_d;
    logic [CNT_WIDTH-1:0]  bubble_cnt_q, bubble_cnt_d;
    logic                  ld_use, load, bubble;
    always_comb begin
        ld_use = valid_q & (mem_ctrl_q == 2'b10) & (rt_addr_q != '0) & valid_i &
                 ((rt_addr_q == rs_addr_i) | (rt_addr_q == rt_addr_i));
        load   = ~flush_i & ~stall_i & ~ld_use;
        bubble = flush_i | (~stall_i & ld_use);
        valid_d      = load ? valid_i : (bubble ? 1'b0 : valid_q);
        ex_ctrl_d    = load ? (valid_i ? EX_ctrl_i : 4'b0) : (bubble ? 4'b0 : ex_ctrl_q);
        mem_ctrl_d   = load ? (valid_i ? MEM_ctrl_i : 2'b0) : (bubble ? 2'b0 : mem_ctrl_q);
        wb_ctrl_d    = load ? (valid_i & WB_ctrl_i) : (~bubble & wb_ctrl_q);
        pc_d         = load ? pc_i : pc_q;
        rs_data_d    = load ? rs_data_i : rs_data_q;
        rt_data_d    = load ? rt_data_i : rt_data_q;
        imm_d        = load ? imm_i : imm_q;
        rs_addr_d    = load ? rs_addr_i : rs_addr_q;
        rt_addr_d    = load ? rt_addr_i : rt_addr_q;
        rd_addr_d    = load ? rd_addr_i : rd_addr_q;
        bubble_cnt_d = (~flush_i & ~stall_i & ld_use & ~&bubble_cnt_q) ? bubble_cnt_q + 1'b1 : bubble_cnt_q;
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            rs_addr_q    <= '0;
            rt_addr_q    <= '0;
            rd_addr_q    <= '0;
            ex_ctrl_q    <= '0;
            mem_ctrl_q   <= '0;
            wb_ctrl_q    <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_q        <= imm_d;
            rs_addr_q    <= rs_addr_d;
            rt_addr_q    <= rt_addr_d;
            rd_addr_q    <= rd_addr_d;
            ex_ctrl_q    <= ex_ctrl_d;
            mem_ctrl_q   <= mem_ctrl_d;
            wb_ctrl_q    <= wb_ctrl_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end
    assign valid_o        = valid_q;
    assign pc_o           = pc_q;
    assign rs_data_o      = rs_data_q;
    assign rt_data_o      = rt_data_q;
    assign imm_o          = imm_q;
    assign rs_addr_o      = rs_addr_q;
    assign rt_addr_o      = rt_addr_q;
    assign rd_addr_o      = rd_addr_q;
    assign EX_ctrl_o      = ex_ctrl_q;
    assign MEM_ctrl_o     = mem_ctrl_q;
    assign WB_ctrl_o      = wb_ctrl_q;
    assign dst_addr_o     = ex_ctrl_q[0] ? rd_addr_q : rt_addr_q;
    assign hazard_stall_o = ld_use & ~flush_i;
    assign bubble_cnt_o   = bubble_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven directed vectors for id_ex_stage built with a 2-bit bubble counter
module tb_id_ex_stage;
    logic        clk_i = 1'b0, rst_n_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0, valid_i = 1'b0;
    logic [31:0] pc_i = '0, rs_data_i = '0, rt_data_i = '0, imm_i = '0;
    logic [4:0]  rs_addr_i = '0, rt_addr_i = '0, rd_addr_i = '0;
    logic [3:0]  EX_ctrl_i = '0;
    logic [1:0]  MEM_ctrl_i = '0;
    logic        WB_ctrl_i = 1'b0;
    logic        valid_o, WB_ctrl_o, hazard_stall_o;
    logic [31:0] pc_o, rs_data_o, rt_data_o, imm_o;
    logic [4:0]  rs_addr_o, rt_addr_o, rd_addr_o, dst_addr_o;
    logic [3:0]  EX_ctrl_o;
    logic [1:0]  MEM_ctrl_o, bubble_cnt_o;
    int checks = 0, errors = 0;
    id_ex_stage #(.DATA_WIDTH(32), .RA_WIDTH(5), .CNT_WIDTH(2)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
        .pc_i(pc_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i),
        .EX_ctrl_i(EX_ctrl_i), .MEM_ctrl_i(MEM_ctrl_i), .WB_ctrl_i(WB_ctrl_i),
        .valid_o(valid_o), .pc_o(pc_o), .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_o(imm_o),
        .rs_addr_o(rs_addr_o), .rt_addr_o(rt_addr_o), .rd_addr_o(rd_addr_o),
        .EX_ctrl_o(EX_ctrl_o), .MEM_ctrl_o(MEM_ctrl_o), .WB_ctrl_o(WB_ctrl_o),
        .dst_addr_o(dst_addr_o), .hazard_stall_o(hazard_stall_o), .bubble_cnt_o(bubble_cnt_o)
    );
    always #5 clk_i = ~clk_i;
    typedef struct {
        logic stall, flush, valid;
        logic [31:0] pc;
        logic [4:0] rs, rt, rd;
        logic [3:0] ex;
        logic [1:0] mem;
        logic wb, e_haz, e_valid;
        logic [3:0] e_ex;
        logic [1:0] e_mem;
        logic e_wb;
        logic [31:0] e_pc;
        logic [4:0] e_dst;
        logic [1:0] e_cnt;
    } vec_t;
    vec_t vq[$];
    task automatic add(input logic s, f, v, input logic [31:0] pc, input logic [4:0] rs, rt, rd,
                       input logic [3:0] ex, input logic [1:0] mem, input logic wb,
                       input logic e_haz, e_valid, input logic [3:0] e_ex, input logic [1:0] e_mem,
                       input logic e_wb, input logic [31:0] e_pc, input logic [4:0] e_dst, input logic [1:0] e_cnt);
        vec_t t;
        t.stall = s; t.flush = f; t.valid = v; t.pc = pc; t.rs = rs; t.rt = rt; t.rd = rd;
        t.ex = ex; t.mem = mem; t.wb = wb; t.e_haz = e_haz; t.e_valid = e_valid; t.e_ex = e_ex;
        t.e_mem = e_mem; t.e_wb = e_wb; t.e_pc = e_pc; t.e_dst = e_dst; t.e_cnt = e_cnt;
        vq.push_back(t);
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, " valid"}, 32'(valid_o), 32'd0);
        chk({tag, " pc"}, pc_o, 32'd0);
        chk({tag, " rs_data"}, rs_data_o, 32'd0);
        chk({tag, " ex"}, 32'(EX_ctrl_o), 32'd0);
        chk({tag, " mem"}, 32'(MEM_ctrl_o), 32'd0);
        chk({tag, " wb"}, 32'(WB_ctrl_o), 32'd0);
        chk({tag, " rt_addr"}, 32'(rt_addr_o), 32'd0);
        chk({tag, " cnt"}, 32'(bubble_cnt_o), 32'd0);
    endtask
    initial begin
        logic [1:0] c;
        logic [31:0] p;
        // ADD, LW rt=5, dependent ADD (bubble), ADD retried
        add(0,0,1, 32'h100, 1,2,3, 4'b0001, 2'b00, 1,  0, 1, 4'b0001, 2'b00, 1, 32'h100, 3, 0);
        add(0,0,1, 32'h104, 1,5,0, 4'b0110, 2'b10, 1,  0, 1, 4'b0110, 2'b10, 1, 32'h104, 5, 0);
        add(0,0,1, 32'h108, 5,6,7, 4'b0001, 2'b00, 1,  1, 0, 4'b0000, 2'b00, 0, 32'h104, 5, 1);
        add(0,0,1, 32'h108, 5,6,7, 4'b0001, 2'b00, 1,  0, 1, 4'b0001, 2'b00, 1, 32'h108, 7, 1);
        for (int i = 0; i < 3; i++)
            add(1,0,1, 32'h200 + 32'(i), 9,9,9, 4'b1110, 2'b11, 1,  0, 1, 4'b0001, 2'b00, 1, 32'h108, 7, 1);
        // LW rt=4 then dependent ADD under flush+stall
        add(0,0,1, 32'h10C, 0,4,0, 4'b0110, 2'b10, 1,  0, 1, 4'b0110, 2'b10, 1, 32'h10C, 4, 1);
        add(1,1,1, 32'h110, 4,1,2, 4'b0001, 2'b00, 1,  0, 0, 4'b0000, 2'b00, 0, 32'h10C, 4, 1);
        add(0,0,0, 32'h114, 0,0,0, 4'b1111, 2'b11, 1,  0, 0, 4'b0000, 2'b00, 0, 32'h114, 0, 1);
        c = 2'd1;
        for (int k = 0; k < 4; k++) begin
            p = 32'h300 + 32'(k * 16);
            add(0,0,1, p, 0,9,0, 4'b0110, 2'b10, 1,  0, 1, 4'b0110, 2'b10, 1, p, 9, c);
            c = (c == 2'd3) ? 2'd3 : c + 2'd1;
            add(0,0,1, p+4, 0,9,10, 4'b0001, 2'b00, 1,  1, 0, 4'b0000, 2'b00, 0, p, 9, c);
            add(0,0,1, p+4, 0,9,10, 4'b0001, 2'b00, 1,  0, 1, 4'b0001, 2'b00, 1, p+4, 10, c);
        end
        // flush alone over a load-use pair, then LW to r0 which must never stall
        add(0,0,1, 32'h400, 0,9,0, 4'b0110, 2'b10, 1,  0, 1, 4'b0110, 2'b10, 1, 32'h400, 9, 3);
        add(0,1,1, 32'h404, 9,1,2, 4'b0001, 2'b00, 1,  0, 0, 4'b0000, 2'b00, 0, 32'h400, 9, 3);
        add(0,0,1, 32'h500, 0,0,0, 4'b0110, 2'b10, 1,  0, 1, 4'b0110, 2'b10, 1, 32'h500, 0, 3);
        add(0,0,1, 32'h504, 0,0,3, 4'b0001, 2'b00, 1,  0, 1, 4'b0001, 2'b00, 1, 32'h504, 3, 3);
        repeat (2) @(posedge clk_i);
        #1;
        chk_zero("reset");
        rst_n_i = 1'b1;
        foreach (vq[n]) begin
            stall_i = vq[n].stall; flush_i = vq[n].flush; valid_i = vq[n].valid;
            pc_i = vq[n].pc; rs_data_i = vq[n].pc + 1; rt_data_i = vq[n].pc + 2; imm_i = vq[n].pc + 3;
            rs_addr_i = vq[n].rs; rt_addr_i = vq[n].rt; rd_addr_i = vq[n].rd;
            EX_ctrl_i = vq[n].ex; MEM_ctrl_i = vq[n].mem; WB_ctrl_i = vq[n].wb;
            #1;
            chk($sformatf("v%0d hazard", n), 32'(hazard_stall_o), 32'(vq[n].e_haz));
            @(posedge clk_i);
            #1;
            chk($sformatf("v%0d valid", n), 32'(valid_o), 32'(vq[n].e_valid));
            chk($sformatf("v%0d ex", n), 32'(EX_ctrl_o), 32'(vq[n].e_ex));
            chk($sformatf("v%0d mem", n), 32'(MEM_ctrl_o), 32'(vq[n].e_mem));
            chk($sformatf("v%0d wb", n), 32'(WB_ctrl_o), 32'(vq[n].e_wb));
            chk($sformatf("v%0d pc", n), pc_o, vq[n].e_pc);
            chk($sformatf("v%0d rs_data", n), rs_data_o, vq[n].e_pc + 1);
            chk($sformatf("v%0d rt_data", n), rt_data_o, vq[n].e_pc + 2);
            chk($sformatf("v%0d imm", n), imm_o, vq[n].e_pc + 3);
            chk($sformatf("v%0d dst", n), 32'(dst_addr_o), 32'(vq[n].e_dst));
            chk($sformatf("v%0d cnt", n), 32'(bubble_cnt_o), 32'(vq[n].e_cnt));
        end
        // asynchronous reset between edges, while stall and flush are both up
        stall_i = 1'b1; flush_i = 1'b1;
        #2;
        rst_n_i = 1'b0;
        #1;
        chk_zero("async_reset");
        @(posedge clk_i);
        #1;
        chk_zero("reset_hold");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
